wr_pointer_full: RTL and testbench
==================================

# wr_pointer_full

Write-side pointer and full-flag generator for the dual-clock FIFO in the Ethernet MAC datapath, running entirely in the write clock domain. Holds the binary and Gray write pointers, synchronises the read domain's Gray pointer, and produces registered full, almost-full and fill-level outputs. Write acceptance is qualified here, so the RAM write port only needs `wr_fire` and `wr_addr`.

## Interface
- `SIZE`, 8: address width; FIFO depth = 2^SIZE; pointers are SIZE+1 bits; SIZE >= 2.
- `AFULL_THRESH`, 2^SIZE-2: fill level at which `almost_full` asserts; legal range 1..2^SIZE.

- `wclk` in 1: write clock; all flops on the rising edge.
- `wr_arstn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write request.
- `rd_ptr_gray` in SIZE+1: read pointer in Gray code, from the read clock domain (asynchronous).
- `ovf_clr` in 1: clears the sticky `overflow`.
- `wr_fire` out 1: `wr_en && !full`, combinational; RAM write enable.
- `wr_addr` out SIZE: `wr_ptr[SIZE-1:0]`.
- `wr_ptr` out SIZE+1: binary write pointer, registered.
- `wr_ptr_gray` out SIZE+1: Gray write pointer, registered; goes to the read-domain synchroniser.
- `full` out 1: registered.
- `almost_full` out 1: registered.
- `wr_level` out SIZE+1: registered fill level, 0..2^SIZE.
- `overflow` out 1: sticky write-while-full flag.

## Operation
- Reset (`wr_arstn` low, takes effect immediately): `wr_ptr`, `wr_ptr_gray`, both sync stages, `wr_level` and `overflow` = 0; `full` = 0; `almost_full` = 0.
- Synchroniser: two flops, `rsync1 <= rd_ptr_gray` and `rsync2 <= rsync1`. The raw input feeds nothing else.
- Next pointer: `wbin_nxt = wr_ptr + wr_fire`, with modulo 2^(SIZE+1) wrap. `wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1)`.
- Full: `full <= (wgray_nxt == {~rsync2[SIZE:SIZE-1], rsync2[SIZE-2:0]})`.
- Level: `rbin` is the Gray-to-binary conversion of `rsync2`. `wr_level <= (wbin_nxt - rbin)` mod 2^(SIZE+1). `almost_full <= (that value >= AFULL_THRESH)`.
- Write accepted (`wr_fire`): `wr_ptr` and `wr_ptr_gray` advance by one.
- Write while full (`wr_en && full`): pointers hold, no RAM write, `overflow` sets.
- Overflow priority: set has priority over `ovf_clr` in the same cycle; otherwise `ovf_clr` clears it.
- `full`, `almost_full` and `wr_level` are all derived from the same next-state values, so they are mutually consistent in every cycle.

## Timing
- Write to flags: a write accepted at edge N updates `full`, `wr_level` and `almost_full` at edge N. The write that fills the FIFO raises `full` on its own edge, so the following cycle's `wr_en` is blocked.
- Read-pointer change: a change of `rd_ptr_gray` before edge N is captured in `rsync1` at N and `rsync2` at N+1. It is reflected in `full`, `wr_level` and `almost_full` at edge N+2. Flags are therefore pessimistic by at most 3 write clocks.
- Write pointer out: `wr_ptr_gray` changes exactly on the edge of each accepted write, at most one bit per change.
- Wrap: the pointer wraps from 2^(SIZE+1)-1 to 0; the MSB toggle distinguishes full from empty.
- Simultaneous write and read-pointer advance: both are included in the same next-state computation; level is unchanged.
- Reset mid-burst: everything clears asynchronously. `wr_fire` is 0 while reset is low. The first edge after release behaves as an empty FIFO.

## Configuration
- `WR_PTR_OVF_EN` defined: `overflow` and `ovf_clr` are functional as described above.
- `WR_PTR_OVF_EN` undefined: the overflow flop is omitted, `overflow` is tied to 0 and `ovf_clr` is ignored. Writes while full are still blocked.

## Test plan
All scenarios use SIZE=3 and AFULL_THRESH=6 unless stated.
- Fill: `rd_ptr_gray`=0, 8 consecutive `wr_en` cycles → `wr_addr` 0..7; `wr_level` steps to 8; `almost_full` rises on the 6th write edge; `full` rises on the 8th; `wr_ptr`=4'b1000, `wr_ptr_gray`=4'b1100.
- Overflow: while full, `wr_en`=1 for 1 cycle → `wr_fire`=0, `wr_ptr` holds at 8, `overflow`=1. Assert `ovf_clr` → `overflow`=0 next edge. Assert `wr_en` and `ovf_clr` together while full → `overflow` stays 1. With the macro undefined → `overflow` stays 0.
- Drain visibility: from full, set `rd_ptr_gray`=4'b0001 → `full` falls and `wr_level`=7 exactly 3 edges later; `almost_full` stays 1.
- Wrap: loop writes and reads (read pointer stepped in Gray) for 40 writes → `wr_ptr` wraps 15→0; `full` only when level is 8; `wr_ptr_gray` has single-bit changes throughout.
- Simultaneous: at level 5, write while `rd_ptr_gray` advances by one → after the sync delay, level returns to 5 and `almost_full` never glitches high.
- Reset: pull `wr_arstn` low mid-burst at level 6 → all outputs are 0 immediately, without waiting for a clock edge; after release, the next write goes to `wr_addr`=0.

Source files
------------

// File: rtl/wr_pointer_full.sv
// Write-side pointers and full/almost-full/level flags for a dual-clock FIFO. Flags are registered and include a write on its own edge; read-pointer changes reach them 2 edges after capture.
// Writes are blocked while full (wr_fire=0). Define WR_PTR_OVF_EN to enable the sticky write-while-full overflow flag.
module wr_pointer_full #(
  parameter int SIZE         = 8,
  parameter int AFULL_THRESH = (1 << SIZE) - 2
) (
  input  logic            wclk,
  input  logic            wr_arstn,
  input  logic            wr_en,
  input  logic [SIZE:0]   rd_ptr_gray,
  input  logic            ovf_clr,
  output logic            wr_fire,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE:0]   wr_ptr,
  output logic [SIZE:0]   wr_ptr_gray,
  output logic            full,
  output logic            almost_full,
  output logic [SIZE:0]   wr_level,
  output logic            overflow
);

  localparam logic [SIZE:0] AF_TH = (SIZE+1)'(AFULL_THRESH);

  logic [SIZE:0] rsync1;
  logic [SIZE:0] rsync2;
  logic [SIZE:0] rbin;
  logic [SIZE:0] wbin_nxt;
  logic [SIZE:0] wgray_nxt;
  logic [SIZE:0] level_nxt;
  logic          full_nxt;
  logic          afull_nxt;

  // Reset gates the enable so nothing reaches the RAM while the domain is held.
  assign wr_fire = wr_en & ~full & wr_arstn;
  assign wr_addr = wr_ptr[SIZE-1:0];

  assign wbin_nxt  = wr_ptr + {{SIZE{1'b0}}, wr_fire};
  assign wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= SIZE; i++) begin
      rbin[i] = ^(rsync2 >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign full_nxt  = (wgray_nxt == {~rsync2[SIZE:SIZE-1], rsync2[SIZE-2:0]});
  assign level_nxt = wbin_nxt - rbin;
  assign afull_nxt = (level_nxt >= AF_TH);

  always_ff @(posedge wclk or negedge wr_arstn) begin
    if (!wr_arstn) begin
      rsync1 <= '0;
      rsync2 <= '0;
    end else begin
      rsync1 <= rd_ptr_gray;
      rsync2 <= rsync1;
    end
  end

  always_ff @(posedge wclk or negedge wr_arstn) begin
    if (!wr_arstn) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      wr_ptr      <= wbin_nxt;
      wr_ptr_gray <= wgray_nxt;
      full        <= full_nxt;
      almost_full <= afull_nxt;
      wr_level    <= level_nxt;
    end
  end

`ifdef WR_PTR_OVF_EN
  always_ff @(posedge wclk or negedge wr_arstn) begin
    if (!wr_arstn) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_wr_pointer_full.sv
// Directed bench for wr_pointer_full at SIZE=3, AFULL_THRESH=6.
module tb_wr_pointer_full;

`ifdef WR_PTR_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic       wclk;
  logic       wr_arstn;
  logic       wr_en;
  logic [3:0] rd_ptr_gray;
  logic       ovf_clr;
  logic       wr_fire;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  wr_pointer_full #(.SIZE(3), .AFULL_THRESH(6)) dut (
    .wclk        (wclk),
    .wr_arstn    (wr_arstn),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .ovf_clr     (ovf_clr),
    .wr_fire     (wr_fire),
    .wr_addr     (wr_addr),
    .wr_ptr      (wr_ptr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       we;
    logic [3:0] rd;
    logic       clr;
    logic       fire;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic we, input logic [3:0] rd, input logic clr,
                              input logic fire, input logic [2:0] addr,
                              input logic [3:0] ptr, input logic [3:0] gray,
                              input logic fl, input logic af, input logic [3:0] lvl,
                              input logic ovf);
    vec_t v;
    v.we = we; v.rd = rd; v.clr = clr; v.fire = fire; v.addr = addr;
    v.ptr = ptr; v.gray = gray; v.full = fl; v.af = af; v.lvl = lvl; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] ptr, input logic [3:0] gray,
                          input logic fl, input logic af, input logic [3:0] lvl, input logic ovf);
    chk({tag, ".wr_ptr"},      32'(wr_ptr),      32'(ptr));
    chk({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 32'(gray));
    chk({tag, ".full"},        32'(full),        32'(fl));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".wr_level"},    32'(wr_level),    32'(lvl));
    chk({tag, ".overflow"},    32'(overflow),    32'(ovf));
  endtask

  initial begin
    logic [3:0] wb;
    logic [3:0] rb;
    logic [3:0] prev_gray;

    wr_arstn    = 1'b0;
    wr_en       = 1'b0;
    rd_ptr_gray = '0;
    ovf_clr     = 1'b0;

    // Fill: eight writes against an empty read pointer.
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(mk(1, 4'b0000, 0, 1, 3'(k-1), 4'(k), b2g(4'(k)),
                        (k == 8), (k >= 6), 4'(k), 0));
    end
    // Overflow set / clear / set-beats-clear / sticky hold / clear.
    vecs.push_back(mk(1, 4'b0000, 0, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, OVF));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, OVF));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, OVF));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, 0));
    // Drain visibility: read pointer 1 seen on the third edge.
    vecs.push_back(mk(0, 4'b0001, 0, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 3'd0, 4'd8, 4'b1100, 1, 1, 4'd8, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 1, 4'd7, 0));
    // Read pointer to 3: level 5, almost_full drops.
    vecs.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 1, 4'd7, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 1, 4'd7, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 0, 4'd5, 0));
    // Read advance to 4 lands in the same next-state as a write: level stays 5.
    vecs.push_back(mk(0, 4'b0110, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 0, 4'd5, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 0, 3'd0, 4'd8, 4'b1100, 0, 0, 4'd5, 0));
    vecs.push_back(mk(1, 4'b0110, 0, 1, 3'd0, 4'd9, 4'b1101, 0, 0, 4'd5, 0));
    vecs.push_back(mk(0, 4'b0110, 0, 0, 3'd1, 4'd9, 4'b1101, 0, 0, 4'd5, 0));

    #1;
    chk_regs("reset", 4'd0, 4'd0, 0, 0, 4'd0, 0);
    chk("reset.wr_fire", 32'(wr_fire), 32'd0);
    #11;
    wr_arstn = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      wr_en       = vecs[i].we;
      rd_ptr_gray = vecs[i].rd;
      ovf_clr     = vecs[i].clr;
      #1;
      chk({tag, ".wr_fire"}, 32'(wr_fire), 32'(vecs[i].fire));
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(vecs[i].addr));
      step();
      chk_regs(tag, vecs[i].ptr, vecs[i].gray, vecs[i].full, vecs[i].af, vecs[i].lvl, vecs[i].ovf);
    end
    ovf_clr = 1'b0;

    // Wrap: one write and one Gray read step per iteration, level holds at 5.
    wb = 4'd9;
    rb = 4'd4;
    prev_gray = wr_ptr_gray;
    for (int i = 0; i < 40; i++) begin
      wr_en       = 1'b1;
      rd_ptr_gray = b2g(rb + 4'd1);
      #1;
      chk($sformatf("wrap%0d.wr_addr", i), 32'(wr_addr), 32'(wb[2:0]));
      step();
      wb = wb + 4'd1;
      rb = rb + 4'd1;
      chk($sformatf("wrap%0d.gray_1bit", i), 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
      prev_gray = wr_ptr_gray;
      wr_en = 1'b0;
      step(); step(); step();
      chk($sformatf("wrap%0d.wr_ptr", i),    32'(wr_ptr),      32'(wb));
      chk($sformatf("wrap%0d.gray", i),      32'(wr_ptr_gray), 32'(b2g(wb)));
      chk($sformatf("wrap%0d.level", i),     32'(wr_level),    32'd5);
      chk($sformatf("wrap%0d.full", i),      32'(full),        32'd0);
      chk($sformatf("wrap%0d.af", i),        32'(almost_full), 32'd0);
    end

    // Fill to 8 with both pointers wrapped (wb=1, rb=12).
    for (int k = 6; k <= 8; k++) begin
      wr_en = 1'b1;
      step();
      wb = wb + 4'd1;
      chk_regs($sformatf("wfill%0d", k), wb, b2g(wb), (k == 8), 1, 4'(k), 0);
    end
    #1;
    chk("wfull.wr_fire", 32'(wr_fire), 32'd0);
    step();
    chk_regs("wfull_ovf", wb, b2g(wb), 1, 1, 4'd8, OVF);

    // Drain to 6, then reset mid-burst.
    wr_en       = 1'b0;
    rd_ptr_gray = b2g(4'd14);
    step(); step(); step();
    chk_regs("pre_rst", wb, b2g(wb), 0, 1, 4'd6, OVF);
    wr_en = 1'b1;
    #2;
    wr_arstn = 1'b0;
    #1;
    chk_regs("async_rst", 4'd0, 4'd0, 0, 0, 4'd0, 0);
    chk("async_rst.wr_fire", 32'(wr_fire), 32'd0);
    chk("async_rst.wr_addr", 32'(wr_addr), 32'd0);
    wr_en       = 1'b0;
    rd_ptr_gray = '0;
    step();
    #3;
    wr_arstn = 1'b1;
    step();
    wr_en = 1'b1;
    #1;
    chk("post_rst.wr_fire", 32'(wr_fire), 32'd1);
    chk("post_rst.wr_addr", 32'(wr_addr), 32'd0);
    step();
    wr_en = 1'b0;
    chk_regs("post_rst", 4'd1, 4'd1, 0, 0, 4'd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
